// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data requesters
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int MEM_LAT = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [63:0]       d_rdata,
    input  logic              halt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state;
    logic own_if, we_q, drop, go, pick_if;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0] wdata_q;
    logic [3:0] cnt, starve;
    assign go = state == IDLE && !rst && !halt && (if_req || d_req);
    assign pick_if = if_req && (!d_req || starve == 4'(STARVE_MAX));
    assign if_gnt = go && pick_if;
    assign d_gnt = go && !pick_if;
    assign mem_en = state == ISSUE && !rst;
    assign mem_we = mem_en && we_q;
    assign mem_addr = mem_en ? addr_q : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign if_rvalid = state == RESP && !rst && own_if && !drop && !if_flush;
    assign d_rvalid = state == RESP && !rst && !own_if;
    assign stall_if = if_req && !if_rvalid;
    assign stall_mem = d_req && !d_rvalid;
    assign busy = state != IDLE;
    // Transaction sequencer: latch the winner, issue, wait out the latency, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            own_if <= 1'b0;
            we_q <= 1'b0;
            drop <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            cnt <= '0;
            starve <= '0;
            if_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (if_flush && (if_gnt || (state != IDLE && own_if))) drop <= 1'b1;
            case (state)
                IDLE: if (go) begin
                    state <= ISSUE;
                    own_if <= pick_if;
                    we_q <= !pick_if && d_we;
                    addr_q <= pick_if ? if_addr : d_addr;
                    wdata_q <= pick_if ? '0 : d_wdata;
                    starve <= pick_if ? '0 : (if_req && starve != 4'(STARVE_MAX)) ? starve + 4'd1 : starve;
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt <= 4'(MEM_LAT - 1);
                end
                WAIT: if (cnt == '0) begin
                    state <= RESP;
                    if (own_if) if_rdata <= addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                    else d_rdata <= we_q ? '0 : mem_rdata;
                end else cnt <= cnt - 4'd1;
                RESP: begin
                    state <= IDLE;
                    drop <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks against a transaction-timing model
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int LAT = 2;
    localparam int SM = 4;
    logic clk = 1'b0;
    logic rst, if_req, if_flush, d_req, d_we, halt;
    logic [AW-1:0] if_addr, d_addr;
    logic [63:0] d_wdata, mem_rdata;
    logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall_if, stall_mem, busy;
    logic [31:0] if_rdata;
    logic [63:0] d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .halt(halt), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    int n_chk = 0, n_fail = 0, cyc = 0, free_at = 0, g = -100, starve = 0;
    bit t_if = 0, t_we = 0, t_drop = 0, m_gif = 0, m_gd = 0;
    logic [AW-1:0] t_addr = '0;
    logic [63:0] t_wdata = '0, e_d_rdata = '0;
    logic [31:0] e_if_rdata = '0;
    int ng_if, ng_d, d_before_if, rv_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A transaction granted at cycle g issues at g+1, samples memory at g+1+LAT,
    // responds at g+2+LAT and leaves the port free from g+3+LAT onwards.
    task automatic tick();
        bit idle, go, pf, issue, resp, e_ifv, e_dv;
        #1;
        idle = cyc >= free_at;
        go = !rst && idle && !halt && (if_req || d_req);
        pf = if_req && (!d_req || starve == SM);
        issue = !rst && !idle && cyc == g + 1;
        resp = !rst && !idle && cyc == g + 2 + LAT;
        e_ifv = resp && t_if && !t_drop && !if_flush;
        e_dv = resp && !t_if;
        chk("if_gnt", if_gnt, go && pf);
        chk("d_gnt", d_gnt, go && !pf);
        chk("mem_en", mem_en, issue);
        chk("mem_we", mem_we, issue && t_we);
        chk("mem_addr", mem_addr, issue ? t_addr : '0);
        chk("mem_wdata", mem_wdata, issue ? t_wdata : '0);
        chk("if_rvalid", if_rvalid, e_ifv);
        chk("d_rvalid", d_rvalid, e_dv);
        chk("busy", busy, !idle);
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        chk("stall_if", stall_if, if_req && !e_ifv);
        chk("stall_mem", stall_mem, d_req && !e_dv);
        m_gif = go && pf;
        m_gd = go && !pf;
        if (rst) begin
            free_at = cyc + 1;
            g = -100;
            starve = 0;
            t_drop = 0;
            e_if_rdata = '0;
            e_d_rdata = '0;
        end else begin
            if (!idle && t_if && if_flush) t_drop = 1;
            if (!idle && cyc == g + 1 + LAT) begin
                if (t_if) e_if_rdata = t_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                else e_d_rdata = t_we ? 64'd0 : mem_rdata;
            end
            if (go) begin
                g = cyc;
                free_at = cyc + 3 + LAT;
                t_if = pf;
                t_we = !pf && d_we;
                t_addr = pf ? if_addr : d_addr;
                t_wdata = pf ? 64'd0 : d_wdata;
                t_drop = pf && if_flush;
                starve = pf ? 0 : (if_req && starve < SM) ? starve + 1 : starve;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1; if_req = 0; if_addr = '0; if_flush = 0; d_req = 0; d_we = 0;
        d_addr = '0; d_wdata = '0; halt = 0; mem_rdata = '0;
        @(posedge clk);
        #1;
        tick();
        rst = 0;
        // single fetch, upper word selected by addr[2]
        if_req = 1; if_addr = 32'h4; mem_rdata = 64'hAAAA_BBBB_1111_2222;
        #1 chk("p1_if_gnt", if_gnt, 1);
        tick();
        if_req = 0;
        #1 chk("p1_mem_en", mem_en, 1);
        tick(); tick(); tick();
        #1 chk("p1_if_rvalid", if_rvalid, 1);
        chk("p1_if_rdata", if_rdata, 32'hAAAABBBB);
        tick();
        repeat (2) tick();
        // simultaneous requests: data first, fetch stalled until served
        if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h100;
        #1 chk("p2_d_gnt", d_gnt, 1);
        chk("p2_if_blocked", if_gnt, 0);
        tick();
        d_req = 0;
        repeat (4) begin
            #1 chk("p2_stall_if", stall_if, 1);
            tick();
        end
        #1 chk("p2_if_gnt", if_gnt, 1);
        tick();
        if_req = 0;
        repeat (6) tick();
        // starvation: both held, fetch must win after STARVE_MAX data grants
        ng_if = 0; ng_d = 0; d_before_if = -1;
        d_req = 1; d_we = 0; d_addr = 32'h108; if_req = 1; if_addr = 32'h20;
        for (int i = 0; i < 26; i++) begin
            #1;
            if (if_gnt && ng_if == 0) d_before_if = ng_d;
            if (if_gnt) ng_if++;
            if (d_gnt) ng_d++;
            tick();
            if (m_gif) if_req = 0;
        end
        d_req = 0;
        chk("p3_d_before_if", d_before_if, 4);
        chk("p3_if_gnts", ng_if, 1);
        chk("p3_d_gnts", ng_d, 5);
        repeat (6) tick();
        // store
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 64'h1234;
        #1 chk("p4_d_gnt", d_gnt, 1);
        tick();
        d_req = 0; d_we = 0;
        #1 chk("p4_mem_en", mem_en, 1);
        chk("p4_mem_we", mem_we, 1);
        chk("p4_mem_addr", mem_addr, 32'h200);
        chk("p4_mem_wdata", mem_wdata, 64'h1234);
        tick(); tick(); tick();
        #1 chk("p4_d_rvalid", d_rvalid, 1);
        chk("p4_d_rdata", d_rdata, 0);
        tick();
        repeat (6) tick();
        // flush during WAIT, with a data request queued behind the fetch
        if_req = 1; if_addr = 32'h8;
        #1 chk("p5_if_gnt", if_gnt, 1);
        tick();
        if_req = 0; d_req = 1; d_we = 0; d_addr = 32'h300;
        tick();
        if_flush = 1;
        tick();
        if_flush = 0;
        tick();
        #1 chk("p5_if_rvalid_dropped", if_rvalid, 0);
        chk("p5_busy_resp", busy, 1);
        tick();
        #1 chk("p5_busy_idle", busy, 0);
        chk("p5_d_gnt", d_gnt, 1);
        tick();
        d_req = 0;
        repeat (6) tick();
        // reset while waiting on memory
        if_req = 1; if_addr = 32'hC;
        tick();
        if_req = 0;
        tick();
        rst = 1;
        #1 chk("p6_busy_wait", busy, 1);
        tick();
        rst = 0;
        #1 chk("p6_busy_after_rst", busy, 0);
        rv_seen = 0;
        repeat (6) begin
            #1 if (if_rvalid || d_rvalid) rv_seen++;
            tick();
        end
        chk("p6_no_rvalid", rv_seen, 0);
        // halt blocks new grants
        halt = 1; if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 1; d_addr = 32'h208; d_wdata = 64'hFEED;
        repeat (4) begin
            #1 chk("p7_halt_no_gnt", if_gnt || d_gnt, 0);
            tick();
        end
        halt = 0;
        #1 chk("p7_d_gnt", d_gnt, 1);
        tick();
        d_req = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m_gif) if_req = 0;
        end
        repeat (6) tick();
        // random traffic
        for (int i = 0; i < 600; i++) begin
            if (m_gif) if_req = 0;
            if (m_gd) d_req = 0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1;
                if_addr = $urandom & 32'h0000_0FFC;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1;
                d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom & 32'h0000_0FF8;
                d_wdata = {$urandom, $urandom};
            end
            halt = $urandom_range(0, 7) == 0;
            if_flush = $urandom_range(0, 9) == 0;
            rst = $urandom_range(0, 149) == 0;
            mem_rdata = {$urandom, $urandom};
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer sharing one single-port unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage loads/stores) of the 5-stage pipeline. It grants one requester per transaction, drives the memory port for a fixed-latency access, returns read data with a one-cycle valid pulse and raises per-stage stall signals until completion. Data accesses take priority, and a starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 32, byte-address width of all address ports
- MEM_LAT, 2, cycles from the ISSUE cycle to valid mem_rdata; legal range 1..15
- STARVE_MAX, 4, consecutive fetch losses after which fetch wins; legal range 1..15
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch byte address (4-byte aligned)
- if_flush  in  1  discard result of in-flight fetch
- if_gnt  out  1  one-cycle pulse, fetch request accepted
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address (8-byte aligned)
- d_wdata  in  64  store data
- d_gnt  out  1  one-cycle pulse, data request accepted
- d_rvalid  out  1  one-cycle pulse, load data valid or store complete
- d_rdata  out  64  load data; 0 on store completion
- halt  in  1  block new grants; in-flight access completes
- mem_en  out  1  memory access strobe (ISSUE cycle only)
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  memory read data
- stall_if  out  1  if_req & ~if_rvalid
- stall_mem  out  1  d_req & ~d_rvalid
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if halt=0 and any request, grant combinationally in the same cycle; latch owner, we, addr, wdata; go to ISSUE. No request or halt=1: stay.
- Priority: d_req wins unless starve_cnt == STARVE_MAX and if_req=1, then fetch wins.
- starve_cnt (4 bits): +1 on each IDLE grant to data while if_req=1; cleared on fetch grant; saturates at STARVE_MAX.
- ISSUE: mem_en=1, mem_we=latched we, mem_addr/mem_wdata from latches (0 otherwise); load wait counter with MEM_LAT-1; go to WAIT (or directly to capture if MEM_LAT=1).
- WAIT: decrement counter; at 0, capture mem_rdata into rdata register; go to RESP.
- RESP: pulse owner's rvalid; state goes to IDLE; new arbitration possible next cycle.
- Fetch: if_rdata = latched addr[2] ? rdata[63:32] : rdata[31:0].
- Stores: mem_we=1, d_rvalid pulses in RESP with d_rdata=0.
- if_flush: if a fetch is owned (ISSUE/WAIT/RESP) or being granted, set drop flag; transaction still completes on memory, if_rvalid suppressed; drop cleared on return to IDLE. No effect on data transactions or idle state.
- halt during a transaction: no effect until IDLE.
- rst: state IDLE, starve_cnt 0, drop 0, latches 0; in-flight access abandoned, no rvalid.

## Timing
- Reset values: if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy = 0; if_rdata, d_rdata, mem_addr, mem_wdata = 0; stall_* follow inputs.
- Grant at cycle T; mem_en at T+1; mem_rdata sampled at T+1+MEM_LAT; rvalid at T+2+MEM_LAT.
- Transaction period MEM_LAT+3 cycles (grant to next grant); MEM_LAT=2 gives 5.
- gnt, rvalid, mem_en strictly single-cycle; never both grants in one cycle.
- rdata outputs hold value until next capture.

## Test plan
- Reset then if_req=1, if_addr=0x04, mem_rdata=0xAAAA_BBBB_1111_2222, MEM_LAT=2 -> if_gnt cycle 0, mem_en cycle 1, if_rvalid cycle 4, if_rdata=0xAAAABBBB.
- Simultaneous if_req and d_req (load 0x100) -> d_gnt first, fetch granted at next IDLE; stall_if high throughout until its rvalid.
- d_req held continuously, if_req held, STARVE_MAX=4 -> four data grants then one fetch grant, starve_cnt back to 0.
- Store d_addr=0x200, d_wdata=0x1234 -> ISSUE cycle mem_en=1, mem_we=1, mem_addr=0x200, mem_wdata=0x1234; d_rvalid pulses, d_rdata=0.
- Fetch granted, if_flush pulse in WAIT -> no if_rvalid, busy drops at expected cycle, pending d_req granted next cycle.
- rst asserted in WAIT -> next cycle busy=0, no rvalid ever; halt=1 with requests pending -> no grants until halt=0.
